// File: rtl/sdram_frame_writer_pkg.sv
// Shared types for the SDRAM frame writer: tap select encodings, FSM states
// and the RGB555 packing helper.
package sdram_frame_writer_pkg;

  typedef enum logic [1:0] {
    MODE_RGB555 = 2'd0,
    MODE_BIN    = 2'd1,
    MODE_ERO    = 2'd2,
    MODE_DIL    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_REALIGN  = 2'd3
  } state_e;

  // Keep the top 5 bits of each 12-bit channel; bit 15 stays clear.
  function automatic logic [15:0] pack_rgb555(input logic [11:0] r,
                                              input logic [11:0] g,
                                              input logic [11:0] b);
    return {1'b0, r[11:7], g[11:7], b[11:7]};
  endfunction

endpackage

// File: rtl/sdram_frame_writer_mux.sv
// Combinational tap selector: picks one video stream and widens it to a
// 16-bit FIFO word with its matching valid.
module sdram_frame_writer_mux
  import sdram_frame_writer_pkg::*;
(
  input  logic [1:0]  sel_mode,
  input  logic [11:0] rgb_red,
  input  logic [11:0] rgb_green,
  input  logic [11:0] rgb_blue,
  input  logic        rgb_dval,
  input  logic [7:0]  bin_data,
  input  logic        bin_valid,
  input  logic [7:0]  ero_data,
  input  logic        ero_valid,
  input  logic [7:0]  dil_data,
  input  logic        dil_valid,
  output logic [15:0] pix_data,
  output logic        pix_valid
);

  always_comb begin
    pix_data  = pack_rgb555(rgb_red, rgb_green, rgb_blue);
    pix_valid = rgb_dval;
    case (sel_mode)
      MODE_BIN: begin pix_data = {8'h00, bin_data}; pix_valid = bin_valid; end
      MODE_ERO: begin pix_data = {8'h00, ero_data}; pix_valid = ero_valid; end
      MODE_DIL: begin pix_data = {8'h00, dil_data}; pix_valid = dil_valid; end
      default:  ;
    endcase
  end

endmodule

// File: rtl/sdram_frame_writer.sv
// Frame-aligned pixel packer feeding the SDRAM write FIFO; writes only whole
// frames and pulses the FIFO address reload after any malformed frame.
module sdram_frame_writer
  import sdram_frame_writer_pkg::*;
#(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int LOAD_CYCLES  = 4,
  parameter int CNT_W        = 19
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        capture_en,
  input  logic [1:0]  mode,
  input  logic        frame_valid,
  input  logic [11:0] rgb_red,
  input  logic [11:0] rgb_green,
  input  logic [11:0] rgb_blue,
  input  logic        rgb_dval,
  input  logic [7:0]  bin_data,
  input  logic        bin_valid,
  input  logic [7:0]  ero_data,
  input  logic        ero_valid,
  input  logic [7:0]  dil_data,
  input  logic        dil_valid,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        wr_load,
  output logic        frame_done,
  output logic        frame_error,
  output logic [15:0] err_count
);

  localparam int FRAME_PIXELS = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int LC_W         = $clog2(LOAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] FP_MAX  = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [LC_W-1:0]  LC_LAST = LC_W'(LOAD_CYCLES - 1);
  localparam logic [LC_W-1:0]  LC_ONE  = LC_W'(1);

  state_e            state, state_d;
  logic              fv_q;
  logic [1:0]        mode_q, mode_d;
  logic [CNT_W-1:0]  cnt, cnt_d, cnt_eff;
  logic              overrun, overrun_d;
  logic [LC_W-1:0]   load_cnt, load_cnt_d;
  logic [15:0]       wr_data_d, err_count_d;
  logic              wr_en_d, done_d, error_d;
  logic              sof, eof, start, accept;
  logic [1:0]        sel_mode;
  logic [15:0]       pix_data;
  logic              pix_valid;

  assign sof      = frame_valid & ~fv_q;
  assign eof      = ~frame_valid & fv_q;
  assign start    = (state == ST_WAIT_SOF) & sof & capture_en;
  // The SOF pixel must use the incoming mode, not the stale latched one.
  assign sel_mode = start ? mode : mode_q;
  assign cnt_eff  = start ? '0 : cnt;
  assign accept   = (start | (state == ST_ACTIVE)) & pix_valid & frame_valid;
  assign wr_load  = (state == ST_REALIGN);

  sdram_frame_writer_mux u_mux (
    .sel_mode  (sel_mode),
    .rgb_red   (rgb_red),
    .rgb_green (rgb_green),
    .rgb_blue  (rgb_blue),
    .rgb_dval  (rgb_dval),
    .bin_data  (bin_data),
    .bin_valid (bin_valid),
    .ero_data  (ero_data),
    .ero_valid (ero_valid),
    .dil_data  (dil_data),
    .dil_valid (dil_valid),
    .pix_data  (pix_data),
    .pix_valid (pix_valid)
  );

  always_comb begin
    state_d     = state;
    mode_d      = mode_q;
    cnt_d       = cnt;
    overrun_d   = overrun;
    load_cnt_d  = load_cnt;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data;
    done_d      = 1'b0;
    error_d     = 1'b0;
    err_count_d = err_count;
    case (state)
      ST_IDLE: if (!frame_valid) state_d = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (start) begin
          state_d   = ST_ACTIVE;
          mode_d    = mode;
          cnt_d     = '0;
          overrun_d = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (eof) begin
          if (cnt == FP_MAX && !overrun) begin
            done_d  = 1'b1;
            state_d = ST_WAIT_SOF;
          end else begin
            error_d    = 1'b1;
            if (err_count != 16'hFFFF) err_count_d = err_count + 16'd1;
            load_cnt_d = '0;
            state_d    = ST_REALIGN;
          end
        end
      end
      ST_REALIGN: begin
        load_cnt_d = load_cnt + LC_ONE;
        if (load_cnt == LC_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Accepted pixels past the frame size are dropped and mark the frame bad.
    if (accept) begin
      if (cnt_eff < FP_MAX) begin
        wr_en_d   = 1'b1;
        wr_data_d = pix_data;
        cnt_d     = cnt_eff + CNT_ONE;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      fv_q        <= 1'b1;
      mode_q      <= '0;
      cnt         <= '0;
      overrun     <= 1'b0;
      load_cnt    <= '0;
      wr_en       <= 1'b0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_d;
      fv_q        <= frame_valid;
      mode_q      <= mode_d;
      cnt         <= cnt_d;
      overrun     <= overrun_d;
      load_cnt    <= load_cnt_d;
      wr_en       <= wr_en_d;
      wr_data     <= wr_data_d;
      frame_done  <= done_d;
      frame_error <= error_d;
      err_count   <= err_count_d;
    end
  end

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Randomized scoreboard bench for sdram_frame_writer with an 8x4 frame.
module tb_sdram_frame_writer;

  localparam int FP = 32;
  localparam int LC = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        capture_en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        frame_valid = 1'b0;
  logic [11:0] rgb_red = '0, rgb_green = '0, rgb_blue = '0;
  logic        rgb_dval = 1'b0;
  logic [7:0]  bin_data = '0, ero_data = '0, dil_data = '0;
  logic        bin_valid = 1'b0, ero_valid = 1'b0, dil_valid = 1'b0;
  logic [15:0] wr_data, err_count;
  logic        wr_en, wr_load, frame_done, frame_error;

  sdram_frame_writer #(
    .FRAME_WIDTH(8), .FRAME_HEIGHT(4), .LOAD_CYCLES(LC), .CNT_W(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .capture_en(capture_en), .mode(mode),
    .frame_valid(frame_valid), .rgb_red(rgb_red), .rgb_green(rgb_green),
    .rgb_blue(rgb_blue), .rgb_dval(rgb_dval), .bin_data(bin_data),
    .bin_valid(bin_valid), .ero_data(ero_data), .ero_valid(ero_valid),
    .dil_data(dil_data), .dil_valid(dil_valid), .wr_data(wr_data),
    .wr_en(wr_en), .wr_load(wr_load), .frame_done(frame_done),
    .frame_error(frame_error), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic is_err; logic [15:0] cnt; } ev_t;

  int          checks = 0, errors = 0;
  int          model_err = 0;
  int          load_run = 0;
  bit          fixed_rgb = 1'b0;
  logic [15:0] exp_q[$];
  ev_t         ev_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output event is matched against the scoreboard queues.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        load_run = 0;
      end else begin
        if (wr_en) begin
          if (exp_q.size() == 0) chk("wr_unexpected", 32'(wr_en), 32'd0);
          else chk("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
        end
        if (frame_done || frame_error) begin
          if (ev_q.size() == 0) chk("pulse_unexpected", {30'd0, frame_done, frame_error}, 32'd0);
          else begin
            e = ev_q.pop_front();
            chk("frame_error", 32'(frame_error), 32'(e.is_err));
            chk("frame_done", 32'(frame_done), 32'(!e.is_err));
            chk("err_count", 32'(err_count), 32'(e.cnt));
          end
        end
        if (wr_load) begin
          chk("wr_en_in_realign", 32'(wr_en), 32'd0);
          load_run++;
        end else if (load_run != 0) begin
          chk("wr_load_len", 32'(load_run), 32'(LC));
          load_run = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic rand_taps();
    if (fixed_rgb) begin
      rgb_red = 12'hFFF; rgb_green = 12'h000; rgb_blue = 12'h880;
    end else begin
      rgb_red = 12'($urandom); rgb_green = 12'($urandom); rgb_blue = 12'($urandom);
    end
    bin_data = 8'($urandom); ero_data = 8'($urandom); dil_data = 8'($urandom);
    rgb_dval = 1'($urandom); bin_valid = 1'($urandom);
    ero_valid = 1'($urandom); dil_valid = 1'($urandom);
  endtask

  task automatic set_sel(input int m, input logic v);
    case (m)
      0: rgb_dval  = v;
      1: bin_valid = v;
      2: ero_valid = v;
      default: dil_valid = v;
    endcase
  endtask

  function automatic logic [15:0] sel_data(input int m);
    case (m)
      0: return {1'b0, rgb_red[11:7], rgb_green[11:7], rgb_blue[11:7]};
      1: return {8'h00, bin_data};
      2: return {8'h00, ero_data};
      default: return {8'h00, dil_data};
    endcase
  endfunction

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_wr_load"}, 32'(wr_load), 32'd0);
    chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_frame_error"}, 32'(frame_error), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  task automatic do_reset(input logic fv);
    reset_n = 1'b0;
    frame_valid = fv;
    tick(); tick();
    check_outputs_zero("reset");
    model_err = 0;
    reset_n = 1'b1;
    tick();
  endtask

  // One frame of n selected-tap pixels with random bubbles. The model only
  // cares which pixels arrive and whether the frame was armed at its start.
  task automatic send_frame(input int n, input int m, input bit cap, input bit partial,
                            input int sw_at, input int sw_mode,
                            input int capoff_at, input int abort_at);
    int  sent = 0;
    bit  captured;
    bit  v;
    ev_t e;
    mode = 2'(m);
    capture_en = cap;
    captured = cap && !partial;
    while (sent < n) begin
      rand_taps();
      frame_valid = 1'b1;
      if (sent == abort_at) begin
        set_sel(m, 1'b0);
        tick();
        reset_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        model_err = 0;
        captured = 1'b0;
        tick();
        reset_n = 1'b1;
        abort_at = -1;
        rand_taps();
      end
      v = ($urandom_range(0, 3) != 0);
      set_sel(m, v);
      if (v) begin
        if (captured && sent < FP) exp_q.push_back(sel_data(m));
        sent++;
        if (sent == sw_at) mode = 2'(sw_mode);
        if (sent == capoff_at) capture_en = 1'b0;
      end
      tick();
    end
    rand_taps();
    frame_valid = 1'b0;
    if (captured) begin
      e.is_err = (n != FP);
      if (e.is_err && model_err < 65535) model_err++;
      e.cnt = 16'(model_err);
      ev_q.push_back(e);
    end
    tick();
    rgb_dval = 1'b0; bin_valid = 1'b0; ero_valid = 1'b0; dil_valid = 1'b0;
    repeat (8 + $urandom_range(0, 3)) tick();
    chk("writes_drained", 32'(exp_q.size()), 32'd0);
    chk("events_drained", 32'(ev_q.size()), 32'd0);
    exp_q.delete();
    ev_q.delete();
  endtask

  initial begin
    int lens[5] = '{30, 31, 32, 32, 33};
    // Nominal RGB frame with fixed colour -> every word 16'h7C11.
    do_reset(1'b0);
    repeat (5) tick();
    fixed_rgb = 1'b1;
    send_frame(32, 0, 1'b1, 1'b0, -1, 0, -1, -1);
    fixed_rgb = 1'b0;

    // Reset released mid-frame: first frame ignored, next one captured.
    do_reset(1'b1);
    send_frame(20, 0, 1'b1, 1'b1, -1, 0, -1, -1);
    send_frame(32, 0, 1'b1, 1'b0, -1, 0, -1, -1);

    // Short frame then recovery.
    send_frame(31, 1, 1'b1, 1'b0, -1, 0, -1, -1);
    send_frame(32, 1, 1'b1, 1'b0, -1, 0, -1, -1);

    // Long frame: only the first 32 pixels are written.
    send_frame(35, 3, 1'b1, 1'b0, -1, 0, -1, -1);

    // Mid-frame mode switch is ignored until the next frame.
    send_frame(32, 1, 1'b1, 1'b0, 10, 2, -1, -1);
    send_frame(32, 2, 1'b1, 1'b0, -1, 0, -1, -1);

    // capture_en drops mid-frame: frame completes, next SOF ignored.
    send_frame(32, 2, 1'b1, 1'b0, -1, 0, 15, -1);
    send_frame(32, 2, 1'b0, 1'b0, -1, 0, -1, -1);

    // Async reset mid-frame, then a fresh full frame.
    send_frame(32, 0, 1'b1, 1'b0, -1, 0, -1, 10);
    send_frame(32, 3, 1'b1, 1'b0, -1, 0, -1, -1);

    for (int i = 0; i < 8; i++)
      send_frame(lens[$urandom_range(0, 4)], int'($urandom_range(0, 3)), 1'b1, 1'b0,
                 -1, 0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_frame_writer.md
Name: sdram_frame_writer

Overview:
- Frame-aligned pixel packer that sits directly upstream of the SDRAM controller's write-side FIFO 1.
- Selects one of the video-stream taps and packs it into 16-bit words: RGB555 from the synchronizer, or the binarized, eroded or dilated 8-bit image.
- Writes only complete frames.
- On a short or long frame it pulses the write-side address reload, so the SDRAM image in front of the VGA reader never drifts out of alignment.

Parameters:
- FRAME_WIDTH, 640, pixels per line
- FRAME_HEIGHT, 480, lines per frame; FRAME_PIXELS = FRAME_WIDTH*FRAME_HEIGHT
- LOAD_CYCLES, 4, length of the wr_load pulse in clk cycles (>=1)
- CNT_W, 19, pixel counter width; must satisfy 2^CNT_W > FRAME_PIXELS

Ports:
- clk  in  1  pixel clock (ccd_pixel_clk domain)
- reset_n  in  1  asynchronous, active-low reset
- capture_en  in  1  allow new frames to start
- mode  in  2  0=RGB555, 1=binarized, 2=eroded, 3=dilated
- frame_valid  in  1  high for the whole active frame
- rgb_red, rgb_green, rgb_blue  in  12 each  synchronizer RGB
- rgb_dval  in  1  RGB pixel valid
- bin_data, bin_valid  in  8/1  binarized tap
- ero_data, ero_valid  in  8/1  eroded tap
- dil_data, dil_valid  in  8/1  dilated tap
- wr_data  out  16  FIFO write data
- wr_en  out  1  FIFO write strobe
- wr_load  out  1  FIFO address reload (to WR1_LOAD)
- frame_done  out  1  one-cycle pulse per complete frame
- frame_error  out  1  one-cycle pulse per rejected frame
- err_count  out  16  saturating count of rejected frames

Behaviour:
- Reset, asynchronous:
  - All outputs go to 0, state IDLE, pixel counter 0.
  - The frame_valid history register fv_q resets to 1, so a frame already in progress at reset release cannot register as a start of frame.
- Edge detect: SOF = frame_valid & ~fv_q; EOF = ~frame_valid & fv_q.
- Source mux, using the mode latched at SOF (mid-frame mode changes are ignored until the next SOF):
  - mode 0: data {1'b0, red[11:7], green[11:7], blue[11:7]}, valid rgb_dval
  - mode 1: data {8'h00, bin_data}, valid bin_valid
  - mode 2: data {8'h00, ero_data}, valid ero_valid
  - mode 3: data {8'h00, dil_data}, valid dil_valid
- States:
  - IDLE: wait for frame_valid==0, then go to WAIT_SOF. This guarantees no partial first frame.
  - WAIT_SOF: on SOF with capture_en=1, latch mode, clear the counter, go to ACTIVE. The SOF cycle's pixel is processed as in ACTIVE. SOF with capture_en=0 is ignored.
  - ACTIVE:
    - A pixel is accepted when the selected valid is 1 and frame_valid is 1.
    - If counter < FRAME_PIXELS: register wr_en=1 and wr_data, then increment the counter.
    - If counter >= FRAME_PIXELS: drop the pixel and set the internal overrun flag. The counter saturates.
    - On EOF, if counter==FRAME_PIXELS and there is no overrun: pulse frame_done and go to WAIT_SOF. Otherwise: pulse frame_error, increment err_count (saturating at 16'hFFFF), and go to REALIGN.
    - A valid pixel on the EOF cycle itself is dropped (frame_valid=0).
  - REALIGN: hold wr_load=1 for exactly LOAD_CYCLES cycles with wr_en=0, then go to IDLE.
- capture_en falling during ACTIVE: the current frame completes normally; no new SOF is accepted.
- Latency: wr_en and wr_data are registered, appearing 1 clk after the accepted input. wr_data holds its last value while wr_en=0.
- wr_en is never high in IDLE, WAIT_SOF or REALIGN.
- frame_done and frame_error are never high in the same cycle.

Decomposition:
- Shared package: mode encodings (MODE_RGB555, MODE_BIN, MODE_ERO, MODE_DIL), state enum, and the RGB555 packing function.
- One natural sub-module, pixel_source_mux: purely combinational mode-to-data/valid selection. The FSM, counter and edge detect stay in the top.

Test Plan (FRAME_WIDTH=8, FRAME_HEIGHT=4, FRAME_PIXELS=32, LOAD_CYCLES=4):
- Nominal RGB: reset, frame_valid low 5 cycles, then a 32-pixel frame in mode 0 with red=12'hFFF, green=0, blue=12'h880 -> 32 wr_en pulses, each wr_data=16'h7C11; frame_done pulses once, 1 cycle after EOF.
- Mid-frame start: release reset with frame_valid already high, 20 pixels, then a clean 32-pixel frame -> no writes for the first frame; 32 writes and one frame_done for the second.
- Short frame: 31 pixels in mode 1 -> 31 writes; frame_error pulses; err_count=1; wr_load high exactly 4 cycles; next 32-pixel frame produces frame_done.
- Long frame: 35 pixels in mode 3 -> exactly 32 writes; frame_error pulses; err_count increments; wr_load pulses.
- Mode switch: set mode=2 at pixel 10 of a mode-1 frame -> all 32 words carry bin_data; the following frame carries ero_data.
- Capture disable plus async reset: drop capture_en mid-frame -> frame completes with 32 writes, next SOF ignored. Then assert reset_n low mid-frame -> all outputs 0 immediately, and no writes until a fresh full frame.
